draw_arbiter: RTL and testbench

- Round-robin arbiter that shares the single VGA framebuffer write port (plot/x/y/colour) between the game's drawing engines: screen clear, dino sprite, obstacle sprite and score digits.
- Sits between those engines and the VGA adapter. The game control FSM's load/generate/game/jump/obstacle strobes start the individual engines; this block only serialises their pixel writes.
- Grants are burst-based: a requester keeps the port until it signals the end of its sprite.

---
 rtl/draw_pkg.sv | 18 +
 rtl/draw_arbiter_rr_pick.sv | 34 +++
 rtl/draw_arbiter.sv | 136 +++++++++++++
 tb/tb_draw_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared draw-path definitions: requester slots, screen size and arbiter state encoding.
package draw_pkg;

  localparam int REQ_CLEAR = 0;
  localparam int REQ_DINO  = 1;
  localparam int REQ_OBS   = 2;
  localparam int REQ_SCORE = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    // NOTE: every output and temporary gets a default before the search, so no latch is inferred.
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Burst round-robin arbiter sharing the VGA framebuffer write port between drawing engines.
// Optional forced release after MAX_BURST pixels when BURST_LIMIT_EN is defined.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOR_W   = 3,
  parameter int MAX_BURST = 64
) (
  input  logic                         Clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           pix_valid,
  input  logic [NUM_REQ-1:0]           last,
  input  logic [NUM_REQ*X_W-1:0]       x_in,
  input  logic [NUM_REQ*Y_W-1:0]       y_in,
  input  logic [NUM_REQ*COLOR_W-1:0]   colour_in,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         plot,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOR_W-1:0]           colour,
  output logic                         busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("MAX_BURST must be at least 1");
  end

  arb_state_t         state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt, owner, owner_nxt, win_idx;
  logic [NUM_REQ-1:0] gnt_nxt, win;
  logic               win_valid, own_pix, burst_end, limit_hit;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  // Only the current owner's strobes matter; everyone else's are ignored.
  assign own_pix = (state == GRANT) && pix_valid[owner];

`ifdef BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] burst_cnt;

  assign limit_hit = own_pix && (burst_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge Clock) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (state == IDLE && win_valid) begin
      burst_cnt <= '0;
    end else if (own_pix && burst_cnt != CNT_W'(MAX_BURST)) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          gnt_nxt   = win;
          owner_nxt = win_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        burst_end = (own_pix && last[owner]) || !req[owner] || limit_hit;
        if (burst_end) begin
          gnt_nxt   = '0;
          ptr_nxt   = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
          state_nxt = GAP;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: pixel registers are reset as well so the framebuffer port is fully defined out of reset.
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      ptr    <= '0;
      owner  <= '0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      // NOTE: non-blocking updates so every register here samples pre-edge values.
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      plot  <= own_pix;
      if (own_pix) begin
        x      <= x_in[int'(owner)*X_W +: X_W];
        y      <= y_in[int'(owner)*Y_W +: Y_W];
        colour <= colour_in[int'(owner)*COLOR_W +: COLOR_W];
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomised scoreboard bench for draw_arbiter: behavioural requester agents plus grant model.
module tb_draw_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int COLOR_W   = 3;
  localparam int MAX_BURST = 64;

  logic                       Clock = 1'b0;
  logic                       reset = 1'b1;
  logic [NUM_REQ-1:0]         req = '0, pix_valid = '0, last = '0, gnt;
  logic [NUM_REQ*X_W-1:0]     x_in = '0;
  logic [NUM_REQ*Y_W-1:0]     y_in = '0;
  logic [NUM_REQ*COLOR_W-1:0] colour_in = '0;
  logic                       plot, busy;
  logic [X_W-1:0]             x;
  logic [Y_W-1:0]             y;
  logic [COLOR_W-1:0]         colour;

  draw_arbiter #(
    .NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .Clock(Clock), .reset(reset), .req(req), .pix_valid(pix_valid), .last(last),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .gnt(gnt), .plot(plot),
    .x(x), .y(y), .colour(colour), .busy(busy)
  );

  always #5 Clock = ~Clock;

  int checks = 0, failures = 0, cyc = 0, plot_count = 0;

  always @(posedge Clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] c;
    int                 due;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;

  // Monitor: every plot must match the oldest expected pixel, exactly one cycle after issue.
  always @(negedge Clock) begin
    if (plot === 1'b1) begin
      plot_count++;
      if (exp_q.size() == 0) begin
        check("plot_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("plot_x", x, mon_e.x);
        check("plot_y", y, mon_e.y);
        check("plot_colour", colour, mon_e.c);
        check("plot_latency", cyc, mon_e.due);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      check("plot_missing", 32'd0, 32'd1);
    end
  end

  // Requester agents: each holds a sprite of rem pixels at (bx+k, by) in colour bc.
  int                 rem[NUM_REQ], sent[NUM_REQ], drop_at[NUM_REQ];
  logic [X_W-1:0]     bx[NUM_REQ];
  logic [Y_W-1:0]     by[NUM_REQ];
  logic [COLOR_W-1:0] bc[NUM_REQ];
  int                 pv_pct = 100;

  // Reference grant model: phase 0 idle, 1 owned, 2 gap.
  int                 m_phase = 0, m_ptr = 0, m_owner = 0, m_burst = 0;
  bit                 end_pend = 1'b0, rst_pend = 1'b1;
  logic [NUM_REQ-1:0] req_drv = '0, prev_g = '0;
  int                 gnt_log[$], exp_log[$];

  function automatic int rr_winner(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic load(input int i, input int len, input int x0, input int y0, input int c0,
                      input int drop = -1);
    rem[i]     = len;
    sent[i]    = 0;
    bx[i]      = X_W'(x0);
    by[i]      = Y_W'(y0);
    bc[i]      = COLOR_W'(c0);
    drop_at[i] = drop;
  endtask

  task automatic tick(input bit do_reset = 1'b0);
    logic [NUM_REQ-1:0]         exp_gnt, g, nreq, npv, nlast;
    logic [NUM_REQ*X_W-1:0]     nx;
    logic [NUM_REQ*Y_W-1:0]     ny;
    logic [NUM_REQ*COLOR_W-1:0] nc;
    bit                         nend, pv, dp;
    pix_t                       e;
    @(negedge Clock);
    if (rst_pend) begin
      m_phase = 0;
      m_ptr   = 0;
      check("reset_plot", plot, 1'b0);
      check("reset_xyc", {x, y, colour}, '0);
    end else begin
      case (m_phase)
        0: if (req_drv != '0) begin
             m_owner = rr_winner(req_drv, m_ptr);
             m_phase = 1;
             m_burst = 0;
           end
        1: if (end_pend) begin
             m_phase = 2;
             m_ptr   = (m_owner + 1) % NUM_REQ;
           end
        default: m_phase = 0;
      endcase
    end
    exp_gnt = (m_phase == 1) ? (NUM_REQ'(1) << m_owner) : '0;
    check("gnt", gnt, exp_gnt);
    check("busy", busy, (m_phase != 0));
    g = gnt;
    if (g != '0 && prev_g == '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) gnt_log.push_back(i);
    end
    prev_g = g;

    nreq = '0; npv = '0; nlast = '0; nend = 1'b0;
    nx = NUM_REQ*X_W'({$urandom, $urandom});
    ny = NUM_REQ*Y_W'({$urandom, $urandom});
    nc = NUM_REQ*COLOR_W'($urandom);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (do_reset) begin
        nreq[i] = (rem[i] > 0);
        npv[i]  = g[i];
      end else if (g[i] === 1'b1) begin
        pv = ($urandom_range(99) < pv_pct);
        if (drop_at[i] >= 0 && sent[i] == drop_at[i]) begin
          dp = pv && (pv_pct < 100) && ($urandom_range(1) == 1);
          nreq[i] = 1'b0;
          nend    = 1'b1;
          rem[i]  = 0;
          drop_at[i] = -1;
        end else begin
          dp = pv && (rem[i] > 0);
          nreq[i] = 1'b1;
          if (!dp) nlast[i] = 1'($urandom_range(1));
        end
        if (dp) begin
          e.x = bx[i] + X_W'(sent[i]);
          e.y = by[i];
          e.c = bc[i];
          e.due = cyc + 1;
          exp_q.push_back(e);
          npv[i] = 1'b1;
          nx[i*X_W +: X_W] = e.x;
          ny[i*Y_W +: Y_W] = e.y;
          nc[i*COLOR_W +: COLOR_W] = e.c;
          sent[i]++;
          m_burst++;
          if (rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) begin
              nlast[i] = 1'b1;
              nend     = 1'b1;
            end
          end
`ifdef BURST_LIMIT_EN
          if (m_burst == MAX_BURST) nend = 1'b1;
`endif
        end
      end else begin
        nreq[i]  = (rem[i] > 0);
        npv[i]   = 1'($urandom_range(1));
        nlast[i] = 1'($urandom_range(1));
      end
    end
    reset     = do_reset;
    req       = nreq;
    pix_valid = npv;
    last      = nlast;
    x_in      = nx;
    y_in      = ny;
    colour_in = nc;
    req_drv   = nreq;
    end_pend  = do_reset ? 1'b0 : nend;
    rst_pend  = do_reset;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NUM_REQ; i++) if (rem[i] > 0) return 1'b0;
    return (m_phase == 0);
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done"}, all_idle(), 1'b1);
    tick();
    tick();
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, gnt_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < gnt_log.size(); i++) begin
      check({name, "_who"}, gnt_log[i], exp_log[i]);
    end
    gnt_log.delete();
  endtask

  initial begin
    int p0, n;
    for (int i = 0; i < NUM_REQ; i++) load(i, 0, 0, 0, 0);

    // Reset held with every engine requesting, then round-robin 0,1,2,3 and wrap to 0.
    for (int i = 0; i < NUM_REQ; i++) load(i, 2, 16 * i, 5 + i, i);
    repeat (3) tick(1'b1);
    drain("rr_first", 100);
    load(0, 2, 100, 60, 5);
    drain("rr_wrap", 50);
    exp_log = '{0, 1, 2, 3, 0};
    check_log("rr_order");

    // Single four-pixel dino burst.
    p0 = plot_count;
    load(1, 4, 10, 20, 6);
    drain("single", 50);
    check("single_plots", plot_count - p0, 4);
    exp_log = '{1};
    check_log("single_order");

    // Obstacle drops req after three pixels; pointer then favours the score engine.
    p0 = plot_count;
    load(2, 10, 50, 30, 2, 3);
    drain("drop", 50);
    check("drop_plots", plot_count - p0, 3);
    gnt_log.delete();
    load(0, 2, 1, 1, 1);
    load(3, 2, 2, 2, 2);
    drain("drop_ptr", 50);
    exp_log = '{3, 0};
    check_log("drop_ptr_order");

    // Long clear stream while the score engine waits.
    p0 = plot_count;
    load(0, 100, 0, 0, 7);
    n = 0;
    while (gnt[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("long_grant0", gnt[0], 1'b1);
    load(3, 2, 140, 100, 4);
    drain("long", 1000);
    check("long_plots", plot_count - p0, 102);
`ifdef BURST_LIMIT_EN
    exp_log = '{0, 3, 0};
`else
    exp_log = '{0, 3};
`endif
    check_log("long_order");

    // Reset in the middle of a dino burst: no stale pixel afterwards.
    load(1, 20, 30, 40, 3);
    n = 0;
    while (gnt[1] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("midrst_grant1", gnt[1], 1'b1);
    repeat (3) tick();
    tick(1'b1);
    for (int i = 0; i < NUM_REQ; i++) load(i, 0, 0, 0, 0);
    repeat (5) tick();
    gnt_log.delete();

    // Random traffic with idle cycles, noise on ungranted lanes and occasional drops.
    pv_pct = 75;
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rem[i] == 0 && gnt[i] !== 1'b1 && $urandom_range(99) < 3) begin
          p0 = $urandom_range(1, 8);
          load(i, p0, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7),
               ($urandom_range(99) < 20) ? $urandom_range(0, p0 - 1) : -1);
        end
      end
      tick();
    end
    drain("random", 2000);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
